// File: rtl/prime_pair_ctrl_if.sv
// Candidate/verdict handshake between the prime-pair sequencer and the prime checker.
interface prime_pair_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] chk_candidate;
  logic             chk_ready;
  logic             chk_done;
  logic             chk_isprime;

  modport master (
    output chk_candidate,
    output chk_ready,
    input  chk_done,
    input  chk_isprime
  );

  modport slave (
    input  chk_candidate,
    input  chk_ready,
    output chk_done,
    output chk_isprime
  );
endinterface

// File: rtl/prime_pair_ctrl.sv
// Searches LFSR-generated odd candidates through an external prime checker until
// two distinct primes are found, or gives up on try exhaustion / checker timeout.
module prime_pair_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MAX_TRIES   = 1024,
  parameter int unsigned CHK_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         seed,
  prime_pair_ctrl_if.master        chk,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [WIDTH-1:0]         prime_p,
  output logic [WIDTH-1:0]         prime_q,
  output logic [15:0]              tries
);

  localparam int unsigned    TW         = $clog2(CHK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(CHK_TIMEOUT - 1);
  localparam logic [15:0]    MAX_T16    = 16'(MAX_TRIES);
  localparam logic [WIDTH-1:0] CAND_FORCE = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_ISSUE, S_WAIT_CHK, S_EVAL, S_DONE, S_FAIL
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lfsr, w_lfsr_nxt;
  logic [WIDTH-1:0] r_cand, w_cand_nxt;
  logic [WIDTH-1:0] r_prime_p, w_prime_p_nxt;
  logic [WIDTH-1:0] r_prime_q, w_prime_q_nxt;
  logic [15:0]      r_tries, w_tries_nxt;
  logic [TW-1:0]    r_tmo, w_tmo_nxt;
  logic             r_done_q;
  logic             r_verdict, w_verdict_nxt;
  logic             r_have_p, w_have_p_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_fail, w_fail_nxt;

  logic [WIDTH-1:0] w_lfsr_step;
  logic             w_done_edge;

  assign w_lfsr_step = {r_lfsr[WIDTH-2:0],
                        r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-11] ^ r_lfsr[1] ^ r_lfsr[0]};
  // A level held high across the issue never looks like a fresh verdict.
  assign w_done_edge = chk.chk_done & ~r_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= '0;
      r_cand    <= '0;
      r_prime_p <= '0;
      r_prime_q <= '0;
      r_tries   <= '0;
      r_tmo     <= '0;
      r_done_q  <= 1'b0;
      r_verdict <= 1'b0;
      r_have_p  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_cand    <= w_cand_nxt;
      r_prime_p <= w_prime_p_nxt;
      r_prime_q <= w_prime_q_nxt;
      r_tries   <= w_tries_nxt;
      r_tmo     <= w_tmo_nxt;
      r_done_q  <= chk.chk_done;
      r_verdict <= w_verdict_nxt;
      r_have_p  <= w_have_p_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_fail    <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_cand_nxt    = r_cand;
    w_prime_p_nxt = r_prime_p;
    w_prime_q_nxt = r_prime_q;
    w_tries_nxt   = r_tries;
    w_tmo_nxt     = r_tmo;
    w_verdict_nxt = r_verdict;
    w_have_p_nxt  = r_have_p;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_fail_nxt    = r_fail;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lfsr_nxt    = (seed == '0) ? ONE_W : seed;
          w_tries_nxt   = '0;
          w_done_nxt    = 1'b0;
          w_fail_nxt    = 1'b0;
          w_prime_p_nxt = '0;
          w_prime_q_nxt = '0;
          w_have_p_nxt  = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_GEN;
        end
      end
      S_GEN: begin
        if (r_tries == MAX_T16) begin
          w_state_nxt = S_FAIL;
        end else begin
          w_lfsr_nxt  = w_lfsr_step;
          w_cand_nxt  = w_lfsr_step | CAND_FORCE;
          w_tries_nxt = (r_tries == 16'hFFFF) ? r_tries : r_tries + 16'd1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_tmo_nxt   = '0;
        w_state_nxt = S_WAIT_CHK;
      end
      S_WAIT_CHK: begin
        w_tmo_nxt = r_tmo + 1'b1;
        if (w_done_edge) begin
          w_verdict_nxt = chk.chk_isprime;
          w_state_nxt   = S_EVAL;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = S_FAIL;
        end
      end
      S_EVAL: begin
        if (!r_verdict) begin
          w_state_nxt = S_GEN;
        end else if (!r_have_p) begin
          w_prime_p_nxt = r_cand;
          w_have_p_nxt  = 1'b1;
          w_state_nxt   = S_GEN;
        end else if (r_cand == r_prime_p) begin
          w_state_nxt = S_GEN;
        end else begin
          w_prime_q_nxt = r_cand;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_FAIL: begin
        w_fail_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign chk.chk_candidate = r_cand;
  assign chk.chk_ready     = (r_state == S_ISSUE);
  assign busy              = r_busy;
  assign done              = r_done;
  assign fail              = r_fail;
  assign prime_p           = r_prime_p;
  assign prime_q           = r_prime_q;
  assign tries             = r_tries;

endmodule

// File: tb/tb_prime_pair_ctrl.sv
// Directed bench for prime_pair_ctrl with behavioural checker models on two instances.
module tb_prime_pair_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] seed_a = '0, seed_b = '0;
  logic        busy_a, done_a, fail_a, busy_b, done_b, fail_b;
  logic [31:0] p_a, q_a, p_b, q_b;
  logic [15:0] tries_a, tries_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prime_pair_ctrl_if #(.WIDTH(32)) ifa ();
  prime_pair_ctrl_if #(.WIDTH(32)) ifb ();

  prime_pair_ctrl #(.WIDTH(32), .MAX_TRIES(1024), .CHK_TIMEOUT(64)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .seed(seed_a), .chk(ifa.master),
    .busy(busy_a), .done(done_a), .fail(fail_a),
    .prime_p(p_a), .prime_q(q_a), .tries(tries_a));

  prime_pair_ctrl #(.WIDTH(32), .MAX_TRIES(4), .CHK_TIMEOUT(64)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .seed(seed_b), .chk(ifb.master),
    .busy(busy_b), .done(done_b), .fail(fail_b),
    .prime_p(p_b), .prime_q(q_b), .tries(tries_b));

  // Checker models: done pulses 2 cycles after the ready edge is sampled.
  logic        hold_a = 1'b0;
  int unsigned rej_a = 0;
  logic        pa, da, va, pb, db;
  int unsigned na;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pa <= 1'b0; da <= 1'b0; va <= 1'b0; na <= 0;
      pb <= 1'b0; db <= 1'b0;
    end else begin
      pa <= ifa.chk_ready;
      da <= pa;
      if (ifa.chk_ready) begin
        va <= (na >= rej_a);
        na <= na + 1;
      end
      pb <= ifb.chk_ready;
      db <= pb;
    end
  end

  assign ifa.chk_done    = hold_a | da;
  assign ifa.chk_isprime = va;
  assign ifb.chk_done    = db;
  assign ifb.chk_isprime = 1'b0;

  // Monitors: ready pulse counts, pulse width and candidate stability.
  int          nrdy_a = 0, nrdy_b = 0, rdy_wide = 0, stab_bad = 0;
  logic        prev_a = 1'b0, prev_b = 1'b0, infl_a = 1'b0;
  logic [31:0] cap_a = '0;

  always @(negedge clk) begin
    if (reset) infl_a = 1'b0;
    if (infl_a && ifa.chk_candidate != cap_a) stab_bad++;
    if (da) infl_a = 1'b0;
    if (ifa.chk_ready) begin
      if (prev_a) rdy_wide++;
      nrdy_a++;
      cap_a  = ifa.chk_candidate;
      infl_a = 1'b1;
    end
    if (ifb.chk_ready) begin
      if (prev_b) rdy_wide++;
      nrdy_b++;
    end
    prev_a = ifa.chk_ready;
    prev_b = ifb.chk_ready;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_a(input logic [31:0] s);
    @(negedge clk);
    seed_a  = s;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_end_a(input string nm);
    bit seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_a || fail_a) begin
        seen = 1;
        break;
      end
    end
    check({nm, "_finished"}, 64'(seen), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] seed;
    logic        hold;
    int unsigned rej;
    logic [31:0] p;
    logic [31:0] q;
    logic [15:0] tries;
    logic        dn;
    logic        fl;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"allprime_s1", 32'd1, 1'b0, 0, 32'h80000003, 32'h80000007, 16'd2, 1'b1, 1'b0};
    vecs[1] = '{"allprime_s0", 32'd0, 1'b0, 0, 32'h80000003, 32'h80000007, 16'd2, 1'b1, 1'b0};
    vecs[2] = '{"reject3",     32'd1, 1'b0, 3, 32'h8000001B, 32'h80000037, 16'd5, 1'b1, 1'b0};
    vecs[3] = '{"timeout",     32'd1, 1'b1, 0, 32'h00000000, 32'h00000000, 16'd1, 1'b0, 1'b1};

    reset = 1'b1;
    #12;
    check("reset_outputs", {busy_a, done_a, fail_a, ifa.chk_ready, tries_a, p_a[15:0], q_a[15:0]}, '0);
    check("reset_cand", 64'(ifa.chk_candidate), 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      int r0;
      hold_a = vecs[v].hold;
      rej_a  = vecs[v].rej;
      do_reset();
      r0 = nrdy_a;
      pulse_a(vecs[v].seed);
      wait_end_a(vecs[v].name);
      @(negedge clk);
      check({vecs[v].name, "_p"},     64'(p_a),     64'(vecs[v].p));
      check({vecs[v].name, "_q"},     64'(q_a),     64'(vecs[v].q));
      check({vecs[v].name, "_tries"}, 64'(tries_a), 64'(vecs[v].tries));
      check({vecs[v].name, "_flags"}, {61'd0, busy_a, done_a, fail_a}, {61'd0, 1'b0, vecs[v].dn, vecs[v].fl});
      check({vecs[v].name, "_readys"}, 64'(nrdy_a - r0), 64'(vecs[v].tries));
    end
    hold_a = 1'b0;
    rej_a  = 0;

    // Restart from done without reset; done must clear while the new search runs.
    do_reset();
    pulse_a(32'd1);
    wait_end_a("first_run");
    pulse_a(32'd2);
    @(negedge clk);
    check("restart_cleared", {62'd0, busy_a, done_a}, {62'd0, 1'b1, 1'b0});
    wait_end_a("restart");
    check("restart_p", 64'(p_a), 64'h80000005);
    check("restart_q", 64'(q_a), 64'h8000000B);
    check("restart_tries", 64'(tries_a), 64'd2);

    // Start during busy is ignored; reset while waiting on the checker aborts.
    hold_a = 1'b1;
    do_reset();
    pulse_a(32'd1);
    repeat (5) @(negedge clk);
    pulse_a(32'd7);
    repeat (2) @(negedge clk);
    check("busy_start_tries", 64'(tries_a), 64'd1);
    check("busy_start_busy", 64'(busy_a), 64'd1);
    check("busy_start_cand", 64'(ifa.chk_candidate), 64'h80000003);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {busy_a, done_a, fail_a, ifa.chk_ready, tries_a, p_a[15:0], q_a[15:0]}, '0);
    check("midreset_cand", 64'(ifa.chk_candidate), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    hold_a = 1'b0;

    // MAX_TRIES=4 instance with a checker that never accepts.
    begin
      int r0;
      bit seen = 0;
      r0 = nrdy_b;
      @(negedge clk);
      seed_b  = 32'd1;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (done_b || fail_b) begin
          seen = 1;
          break;
        end
      end
      check("maxtries_finished", 64'(seen), 64'd1);
      @(negedge clk);
      check("maxtries_flags", {61'd0, busy_b, done_b, fail_b}, {61'd0, 3'b001});
      check("maxtries_tries", 64'(tries_b), 64'd4);
      check("maxtries_readys", 64'(nrdy_b - r0), 64'd4);
    end

    check("ready_width", 64'(rdy_wide), 64'd0);
    check("cand_stable", 64'(stab_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prime_pair_ctrl.md
Name: prime_pair_ctrl

Overview:
- Sequencer that drives `prime_checker_sv` (candidate / ready / done / isprime handshake) to find two distinct odd primes p and q for the RSA key path.
- Generates pseudo-random WIDTH-bit candidates with an LFSR and issues each one to the checker.
- Collects the checker verdicts, latches the first two accepted candidates, and reports done or fail to the key-generation top level.

Parameters:
- WIDTH, 32, candidate/prime width; equals checker candidate width.
- MAX_TRIES, 1024, maximum candidates issued per start before fail.
- CHK_TIMEOUT, 64, maximum cycles waiting for a checker done edge per candidate.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a search; ignored while busy.
- seed  in  WIDTH  LFSR seed, sampled on accepted start.
- chk_candidate  out  WIDTH  candidate to checker, held stable from issue until verdict.
- chk_ready  out  1  one-cycle pulse telling the checker to evaluate chk_candidate.
- chk_done  in  1  checker completion; may be a pulse or a held level.
- chk_isprime  in  1  checker verdict, valid on the cycle chk_done is seen rising.
- busy  out  1  high from accepted start until done/fail.
- done  out  1  high when p and q are valid; held until next accepted start.
- fail  out  1  high after MAX_TRIES exhausted or checker timeout; held until next accepted start.
- prime_p  out  WIDTH  first accepted prime.
- prime_q  out  WIDTH  second accepted prime, never equal to prime_p.
- tries  out  16  candidates issued since last start, saturating at 16'hFFFF.

Behaviour:
- Reset values: every output and register 0, including lfsr, tries, the timeout counter and the done_q edge register; state IDLE. Reset is honoured mid-search and aborts it immediately.
- LFSR: Fibonacci, shift left one step per GEN cycle.
  - new bit0 = l[31]^l[21]^l[1]^l[0].
  - For WIDTH≠32 the taps are l[W-1]^l[W-11]^l[1]^l[0].
  - A zero seed is replaced by 1.
- Candidate forming: cand = lfsr_next | (1<<(WIDTH-1)) | 1, i.e. top bit and LSB are forced.
- Edge detect: done_q registers chk_done every cycle. A verdict is recognised only when chk_done & ~done_q occurs in WAIT_CHK. A stale high level never counts.
- FSM states: IDLE, GEN, ISSUE, WAIT_CHK, EVAL, DONE, FAIL.
  - IDLE: on start, load lfsr←seed (or 1), tries←0, clear done/fail/prime_p/prime_q/have_p, busy←1, go to GEN.
  - GEN: step lfsr, register cand into chk_candidate, tries←tries+1. If tries already == MAX_TRIES, go to FAIL instead (no issue).
  - ISSUE: chk_ready=1 for exactly this one cycle; clear the timeout counter; go to WAIT_CHK.
  - WAIT_CHK: increment the timeout counter each cycle.
    - On done edge: latch verdict, go to EVAL.
    - If the counter reaches CHK_TIMEOUT: go to FAIL.
  - EVAL:
    - If verdict=0: go to GEN.
    - If verdict=1 and !have_p: prime_p←cand, have_p←1, go to GEN.
    - If verdict=1, have_p, and cand==prime_p: treat as reject, go to GEN.
    - Otherwise: prime_q←cand, go to DONE.
  - DONE: done←1, busy←0, go to IDLE.
  - FAIL: fail←1, busy←0, go to IDLE. prime_p keeps whatever was found.
- start while busy is ignored. start in the same cycle DONE/FAIL is entered is ignored. start in IDLE with done=1 restarts the search.
- Latency per candidate: GEN(1) + ISSUE(1) + checker latency + EVAL(1). Against a checker that raises done 2 cycles after ready, the done edge is seen 2 cycles after ISSUE.
- chk_candidate changes only in GEN; it is stable throughout ISSUE..EVAL.
- tries saturates; the MAX_TRIES comparison uses the unsaturated value (MAX_TRIES ≤ 65535 required).

Test Plan:
- seed=1; model answers prime for every candidate → prime_p=32'h80000003, prime_q=32'h80000007, tries=2, done=1, fail=0, busy low after DONE.
- seed=0 → identical results to seed=1 (zero-seed substitution).
- seed=1; model rejects the first 3 candidates and accepts the rest → tries=5, prime_p is the 4th candidate, prime_q is the 5th. Each chk_ready is one cycle wide and chk_candidate is stable until EVAL.
- Model holds chk_done high permanently from reset → first candidate times out after CHK_TIMEOUT cycles; fail=1, done=0, tries=1.
- MAX_TRIES=4; model always answers not-prime → fail=1 with tries=4; exactly 4 chk_ready pulses observed.
- Assert reset mid-WAIT_CHK → all outputs 0 next edge; start pulsed during busy → ignored, tries unaffected.
